// File: rtl/bsa_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package bsa_pkg;

  localparam int BSA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } bsa_state_e;

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full-adder slice used once per clock by the serial datapath; purely combinational.
module serial_fa_slice (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic YS,
  output logic YC
);

  assign YS = A ^ B ^ C;
  assign YC = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one sum bit per clock, WIDTH cycles per operation,
// valid/ready handshake on both sides.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = BSA_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  bsa_state_e       r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_ys, w_yc;

  serial_fa_slice u_fa (
    .A  (r_a[0]),
    .B  (r_b[0]),
    .C  (r_carry),
    .YS (w_ys),
    .YC (w_yc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (IN_VALID)       w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST)  w_next = S_DONE;
      S_DONE:  if (OUT_READY)      w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    case (r_state)
      S_IDLE:  IN_READY  = 1'b1;
      S_RUN:   BUSY      = 1'b1;
      S_DONE:  begin
        OUT_VALID = 1'b1;
        BUSY      = 1'b1;
      end
      default: IN_READY  = 1'b0;
    endcase
  end

  // Counter parks at LAST on the final RUN edge so it never wraps mid-operation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (IN_VALID) begin
          r_a     <= A;
          r_b     <= B;
          r_carry <= CIN;
          r_res   <= '0;
          r_cnt   <= '0;
        end
        S_RUN: begin
          r_res   <= {w_ys, r_res[WIDTH-1:1]};
          r_carry <= w_yc;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign SUM  = r_res;
  assign COUT = r_carry;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized and directed self-checking bench for bit_serial_adder (WIDTH=8).
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         BUSY;

  int checks = 0;
  int errors = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CIN(CIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SUM(SUM), .COUT(COUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic sum.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Accepts one operand set, waits for the result, checks latency and value, then leaves it in DONE.
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                input string tag);
    logic [W:0] e;
    int lat;
    e = ref_add(a, b, c);
    @(negedge CLK);
    chk({tag, "_rdy"}, IN_READY, 1);
    IN_VALID = 1'b1; A = a; B = b; CIN = c; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 0;
    while (!OUT_VALID && lat < 50) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_sum"}, SUM, e[W-1:0]);
    chk({tag, "_cout"}, COUT, e[W]);
    chk({tag, "_busy"}, BUSY, 1);
  endtask

  task automatic release_result(input string tag);
    @(negedge CLK); OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk({tag, "_ovl_low"}, OUT_VALID, 0);
    chk({tag, "_idle"}, IN_READY, 1);
  endtask

  initial begin
    logic [W:0] e;
    logic [W-1:0] hs;
    logic hc;
    logic [W-1:0] qa[$], qb[$];
    logic qc[$];
    int done_ops, cyc, last_acc, n_acc;

    // Reset state
    #3;
    chk("rst_rdy", IN_READY, 1);
    chk("rst_ovl", OUT_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_sum", SUM, 0);
    chk("rst_cout", COUT, 0);
    @(negedge CLK); RST = 1'b0;

    start_and_wait(8'h5A, 8'h3C, 1'b0, "d5a3c"); release_result("d5a3c");
    start_and_wait(8'hFF, 8'h01, 1'b0, "dff01"); release_result("dff01");
    start_and_wait(8'hFF, 8'hFF, 1'b1, "dffff"); release_result("dffff");

    // Stall in DONE with spurious requests
    start_and_wait(8'h81, 8'h7E, 1'b1, "stall");
    e = ref_add(8'h81, 8'h7E, 1'b1);
    hs = SUM; hc = COUT;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; A = 8'h11; B = 8'h22; CIN = 1'b1;
      @(posedge CLK); #1;
      chk("stall_sum", SUM, e[W-1:0]);
      chk("stall_cout", COUT, hc);
      chk("stall_ovl", OUT_VALID, 1);
      chk("stall_rdy", IN_READY, 0);
    end
    chk("stall_hold", SUM, hs);
    @(negedge CLK); IN_VALID = 1'b0;
    release_result("stall");
    repeat (3) @(posedge CLK);
    #1 chk("stall_notaken", BUSY, 0);

    // Reset mid-RUN at counter=3
    @(negedge CLK);
    IN_VALID = 1'b1; A = 8'hC3; B = 8'h5F; CIN = 1'b1;
    @(posedge CLK); #1 IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_sum", SUM, 0);
    chk("arst_cout", COUT, 0);
    chk("arst_ovl", OUT_VALID, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_rdy", IN_READY, 1);
    @(negedge CLK); RST = 1'b0;
    start_and_wait(8'h01, 8'h01, 1'b0, "post_rst"); release_result("post_rst");

    // Back-to-back random stream
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    done_ops = 0; cyc = 0; last_acc = -1; n_acc = 0;
    while (done_ops < 1000 && cyc < 12000) begin
      @(negedge CLK);
      cyc++;
      if (OUT_VALID) begin
        if (qa.size() == 0) chk("b2b_spurious", 1, 0);
        else begin
          e = ref_add(qa.pop_front(), qb.pop_front(), qc.pop_front());
          chk("b2b_sum", SUM, e[W-1:0]);
          chk("b2b_cout", COUT, e[W]);
          done_ops++;
        end
      end
      A = W'($urandom); B = W'($urandom); CIN = 1'($urandom);
      if (IN_READY) begin
        qa.push_back(A); qb.push_back(B); qc.push_back(CIN);
        if (last_acc >= 0) chk("b2b_ii", cyc - last_acc, W + 2);
        last_acc = cyc;
        n_acc++;
      end
    end
    chk("b2b_count", done_ops, 1000);
    IN_VALID = 1'b0; OUT_READY = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits; legal range 2..32.
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port IN_VALID, input, 1, operand request valid.
REQ-005 SHALL have port IN_READY, output, 1, block can accept operands.
REQ-006 SHALL have port A, input, WIDTH, addend A.
REQ-007 SHALL have port B, input, WIDTH, addend B.
REQ-008 SHALL have port CIN, input, 1, carry-in.
REQ-009 SHALL have port OUT_VALID, output, 1, result valid.
REQ-010 SHALL have port OUT_READY, input, 1, consumer accepts result.
REQ-011 SHALL have port SUM, output, WIDTH, (A+B+CIN) mod 2^WIDTH.
REQ-012 SHALL have port COUT, output, 1, carry out of the MSB.
REQ-013 SHALL have port BUSY, output, 1, high in RUN or DONE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: IN_READY=1, OUT_VALID=0; IN_VALID=1 at an edge SHALL load A and B into shift registers, carry register <= CIN, bit counter <= 0, result register <= 0, next state RUN.
REQ-016 RUN: each edge SHALL add bit 0 of the A and B shift registers with the carry register, shift the sum bit into the result register MSB (result shifts right), load the carry register with the carry output, shift A and B right by one, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; the edge processing counter value WIDTH-1 SHALL transfer to DONE.
REQ-018 OUT_VALID SHALL rise exactly WIDTH cycles after the accepting edge; SUM = result register, COUT = carry register.
REQ-019 DONE: OUT_VALID=1; SUM/COUT SHALL be stable while OUT_READY=0, with no timeout.
REQ-020 DONE with OUT_READY=1 at an edge SHALL return to IDLE; OUT_VALID falls at that edge.
REQ-021 IN_READY SHALL be 0 in RUN and DONE; IN_VALID there SHALL be ignored, with no queuing.
REQ-022 Minimum initiation interval SHALL be WIDTH+2 cycles: one IDLE cycle, WIDTH RUN cycles, one DONE cycle.
REQ-023 SUM and COUT SHALL hold their last values in IDLE; only meaningful when OUT_VALID=1.
REQ-024 Counter width SHALL be clog2(WIDTH); it SHALL never wrap within an operation.
REQ-025 Overflow SHALL be reported only through COUT; no saturation.
REQ-026 All outputs SHALL be registered or pure FSM-state decodes; no combinational path from inputs to outputs.

Reset
REQ-027 RST=1 SHALL immediately force: state IDLE, IN_READY=1, OUT_VALID=0, BUSY=0, SUM=0, COUT=0, counter=0, and shift, carry and result registers to 0.
REQ-028 Reset in RUN or DONE SHALL abort the operation silently; no partial result is presented.
REQ-029 The first accept SHALL be possible at the first rising edge after RST deasserts.

Structure
REQ-030 Package bsa_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH constant.
REQ-031 The one-bit add SHALL be a combinational sub-module serial_fa_slice with inputs A, B, C and outputs YS (A^B^C) and YC (majority of A, B, C).
REQ-032 serial_fa_slice SHALL contain no state; all flops SHALL reside in bit_serial_adder.

Verification (WIDTH=8)
REQ-033 A=0x5A, B=0x3C, CIN=0 -> SUM=0x96, COUT=0; OUT_VALID exactly 8 cycles after accept.
REQ-034 A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1; A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1.
REQ-035 OUT_READY held 0 for 5 cycles in DONE, new IN_VALID pulsed -> SUM/COUT/OUT_VALID unchanged, IN_READY=0, new request not taken; OUT_READY=1 -> IDLE next edge.
REQ-036 RST pulsed while RUN counter=3 -> outputs zero with no clock edge, IN_READY=1; after release A=0x01, B=0x01, CIN=0 -> SUM=0x02, COUT=0.
REQ-037 Back-to-back: IN_VALID held 1 with OUT_READY=1 -> accepts spaced exactly 10 cycles, every result correct against a reference model over 1000 random operands.
